// File: rtl/fifo_controller_if.sv
// ----------------------------------------------------------------------------
// fifo_controller_if
//   Handshake bundle between a producer/consumer (master) and the FIFO (slave).
//   Signals:
//     data               master -> slave  write data word
//     write              master -> slave  push request (one push per clock)
//     read               master -> slave  pop request (one pop per clock)
//     empty              slave  -> master occupancy == 0
//     full               slave  -> master occupancy == DEPTH
//     half_full          slave  -> master occupancy >= DEPTH/2
//     three_quarter_full slave  -> master occupancy >= 3*DEPTH/4
//     out                slave  -> master registered read data
// ----------------------------------------------------------------------------
interface fifo_controller_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data;
    logic             write;
    logic             read;
    logic             empty;
    logic             full;
    logic             half_full;
    logic             three_quarter_full;
    logic [WIDTH-1:0] out;

    modport master (
        output data, write, read,
        input  empty, full, half_full, three_quarter_full, out
    );

    modport slave (
        input  data, write, read,
        output empty, full, half_full, three_quarter_full, out
    );
endinterface

// File: rtl/fifo_controller.sv
// ----------------------------------------------------------------------------
// fifo_controller
//   Single-clock FIFO of DEPTH words, WIDTH bits each, with occupancy flags.
//   Used as a rate-matching queue between two blocks in the same clock domain.
//   Ports:
//     i_clk   rising-edge clock
//     i_rst   synchronous reset, active-high; overrides read and write
//     bus     fifo_controller_if.slave: data/write/read in,
//             empty/full/half_full/three_quarter_full/out out
//   A read returns its word on out right after the accepting edge; out holds
//   otherwise. Flags decode the registered count, so they change only after
//   a clock edge and never glitch between edges.
// ----------------------------------------------------------------------------
module fifo_controller #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    fifo_controller_if.slave      bus
);
    localparam logic [AW:0] LP_FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] LP_HALF_CNT = (AW+1)'(DEPTH / 2);
    localparam logic [AW:0] LP_TQ_CNT   = (AW+1)'((3 * DEPTH) / 4);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_out;

    logic             w_empty;
    logic             w_full;
    logic             w_wr_en;
    logic             w_rd_en;

    // Occupancy decode and request qualification.
    always_comb begin
        w_empty = (r_count == (AW+1)'(0));
        w_full  = (r_count == LP_FULL_CNT);
        if (i_rst) begin
            w_wr_en = 1'b0;
            w_rd_en = 1'b0;
        end else begin
            w_wr_en = bus.write && !w_full;
            w_rd_en = bus.read  && !w_empty;
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= bus.data;
        end
    end

    // Pointers, count and registered read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
            r_out    <= {WIDTH{1'b0}};
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_out    <= r_mem[r_rd_ptr];
            end
            // Simultaneous accepted read and write leaves count unchanged.
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Drive interface outputs from registered state.
    always_comb begin
        bus.empty              = w_empty;
        bus.full               = w_full;
        bus.half_full          = (r_count >= LP_HALF_CNT);
        bus.three_quarter_full = (r_count >= LP_TQ_CNT);
        bus.out                = r_out;
    end
endmodule

// File: tb/tb_fifo_controller.sv
// ----------------------------------------------------------------------------
// tb_fifo_controller
//   Scoreboard bench: accepted pushes go into a reference queue; accepted
//   pops take the expected word from its head and compare with out.
// ----------------------------------------------------------------------------
module tb_fifo_controller;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    logic [WIDTH-1:0] sb_q[$];
    logic [WIDTH-1:0] exp_out;

    fifo_controller_if #(.WIDTH(WIDTH)) bus ();

    fifo_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock: drive on negedge, update reference model, check after edge.
    task automatic cycle(input logic r, input logic rd, input logic wr, input logic [WIDTH-1:0] d,
                         input string tag);
        bit wr_acc;
        bit rd_acc;
        int cnt;
        @(negedge clk);
        rst       = r;
        bus.read  = rd;
        bus.write = wr;
        bus.data  = d;
        @(posedge clk);
        #1;
        if (r) begin
            sb_q.delete();
            exp_out = '0;
        end else begin
            wr_acc = wr && (sb_q.size() < DEPTH);
            rd_acc = rd && (sb_q.size() > 0);
            if (rd_acc) exp_out = sb_q.pop_front();
            if (wr_acc) sb_q.push_back(d);
        end
        cnt = sb_q.size();
        chk({tag, ".out"},   bus.out, exp_out);
        chk({tag, ".flags"},
            {28'h0, bus.empty, bus.half_full, bus.three_quarter_full, bus.full},
            {28'h0, cnt == 0, cnt >= DEPTH/2, cnt >= (3*DEPTH)/4, cnt == DEPTH});
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        exp_out   = '0;
        rst       = 1'b1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        bus.data  = '0;

        // Reset for two clocks.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, "rst0");
        cycle(1'b1, 1'b0, 1'b0, 32'h0, "rst1");

        // Push/pop order, then reads on empty hold out.
        cycle(1'b0, 1'b0, 1'b1, 32'h0000ABCD, "push_a");
        cycle(1'b0, 1'b0, 1'b1, 32'h00001234, "push_b");
        cycle(1'b0, 1'b0, 1'b1, 32'h00002345, "push_c");
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, "pop_order");
        chk("after_order.out", bus.out, 32'h00002345);

        // Fill levels, overflow drop, drain in order.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b1, 32'(i), "fill");
        chk("filled.full", {31'h0, bus.full}, 32'h1);
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, "overflow");
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, "drain");
        chk("drain_last.out", bus.out, 32'h0000000F);

        // Wrap-around across pointer overflow.
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 32'h100 + 32'(i), "wrap_push10");
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, "wrap_pop10");
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b1, 32'h200 + 32'(i), "wrap_push12");
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, "wrap_pop12");

        // Simultaneous read+write at count 5, then drain to confirm count.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 32'h300 + 32'(i), "sim_push5");
        cycle(1'b0, 1'b1, 1'b1, 32'h3AA, "sim_rw5");
        chk("sim_rw5.out", bus.out, 32'h00000300);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, "sim_drain");
        chk("sim_drain.empty", {31'h0, bus.empty}, 32'h1);

        // Simultaneous read+write at count 0: write only, no bypass.
        cycle(1'b0, 1'b1, 1'b1, 32'h0BEEF000, "sim_rw0");
        chk("sim_rw0.out", bus.out, 32'h000003AA);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, "sim_rw0_pop");

        // Simultaneous read+write when full: read only.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b1, 32'h400 + 32'(i), "full_push");
        cycle(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, "sim_rw_full");
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, "full_drain");

        // Reset mid-operation with 6 stored and read=write=1.
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 32'h500 + 32'(i), "mid_push");
        cycle(1'b1, 1'b1, 1'b1, 32'h55555555, "mid_rst");
        cycle(1'b0, 1'b1, 1'b0, 32'h0, "mid_rd_empty");
        cycle(1'b0, 1'b0, 1'b1, 32'h00C0FFEE, "post_push");
        cycle(1'b0, 1'b1, 1'b0, 32'h0, "post_pop");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
